mem_sram_responder: RTL and testbench

//  Memory-side responder for the MEM stage's data-access interface (ramOp/ramAddr/storeData in, load data out).

---
 rtl/mem_sram_responder.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_sram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_responder.sv
// MEM-stage data-access responder: runs each load/store as a multi-cycle async-SRAM cycle,
// lane-adjusts and extends load data, and holds the pipeline with stall_o until done.
module mem_sram_responder #(
   parameter int ADDR_W      = 20,
   parameter int READ_WAIT   = 1,
   parameter int WRITE_PULSE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        ramOp_i,
   input  logic [31:0]       ramAddr_i,
   input  logic [31:0]       storeData_i,
   input  logic              flush_i,
   output logic [31:0]       load_data_o,
   output logic              stall_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_dq_o,
   input  logic [31:0]       sram_dq_i,
   output logic              sram_dq_oe_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o,
   output logic [2:0]        dbg_state_o
);

   // Op encoding mirrors the MEM_* codes of the pipeline.
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam int CNT_MAX = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_PULSE = 3'd3,
      S_WR_HOLD  = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [3:0]        r_op, w_op_nxt;
   logic [1:0]        r_lane, w_lane_nxt;
   logic [31:0]       r_load, w_load_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [31:0]       r_dq, w_dq_nxt;
   logic              r_dq_oe, w_dq_oe_nxt;
   logic              r_ce_n, w_ce_n_nxt;
   logic              r_oe_n, w_oe_n_nxt;
   logic              r_we_n, w_we_n_nxt;
   logic [3:0]        r_be_n, w_be_n_nxt;
   logic              w_stall;
   logic              w_is_load, w_is_store;
   logic [31:0]       w_store_lanes;
   logic [3:0]        w_store_be_n;
   logic              w_addr_unused;

   assign w_addr_unused = ^ramAddr_i[31:ADDR_W+2];

   assign w_is_load  = (ramOp_i == OP_LB) || (ramOp_i == OP_LBU) || (ramOp_i == OP_LH) ||
                       (ramOp_i == OP_LHU) || (ramOp_i == OP_LW);
   assign w_is_store = (ramOp_i == OP_SB) || (ramOp_i == OP_SH) || (ramOp_i == OP_SW);

   // Store data is replicated across lanes so the byte enables alone select the target.
   always_comb begin
      w_store_lanes = storeData_i;
      w_store_be_n  = 4'b0000;
      case (ramOp_i)
         OP_SB: begin
            w_store_lanes = {4{storeData_i[7:0]}};
            w_store_be_n  = ~(4'b0001 << ramAddr_i[1:0]);
         end
         OP_SH: begin
            w_store_lanes = {2{storeData_i[15:0]}};
            w_store_be_n  = ramAddr_i[1] ? 4'b0011 : 4'b1100;
         end
         default: begin
            w_store_lanes = storeData_i;
            w_store_be_n  = 4'b0000;
         end
      endcase
   end

   function automatic logic [31:0] f_extend(input logic [3:0]  op,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
      logic [7:0]  v_byte;
      logic [15:0] v_half;
      v_byte = 8'(word >> {lane, 3'b000});
      v_half = lane[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   f_extend = {{24{v_byte[7]}}, v_byte};
         OP_LBU:  f_extend = {24'd0, v_byte};
         OP_LH:   f_extend = {{16{v_half[15]}}, v_half};
         OP_LHU:  f_extend = {16'd0, v_half};
         default: f_extend = word;
      endcase
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_op_nxt    = r_op;
      w_lane_nxt  = r_lane;
      w_load_nxt  = r_load;
      w_addr_nxt  = r_addr;
      w_dq_nxt    = r_dq;
      w_dq_oe_nxt = r_dq_oe;
      w_ce_n_nxt  = r_ce_n;
      w_oe_n_nxt  = r_oe_n;
      w_we_n_nxt  = r_we_n;
      w_be_n_nxt  = r_be_n;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!flush_i && (w_is_load || w_is_store)) begin
               w_stall    = 1'b1;
               w_op_nxt   = ramOp_i;
               w_lane_nxt = ramAddr_i[1:0];
               w_addr_nxt = ramAddr_i[ADDR_W+1:2];
               w_ce_n_nxt = 1'b0;
               if (w_is_load) begin
                  w_oe_n_nxt  = 1'b0;
                  w_be_n_nxt  = 4'b0000;
                  w_cnt_nxt   = CNT_W'(READ_WAIT - 1);
                  w_state_nxt = S_RD;
               end else begin
                  w_dq_oe_nxt = 1'b1;
                  w_dq_nxt    = w_store_lanes;
                  w_be_n_nxt  = w_store_be_n;
                  w_state_nxt = S_WR_SETUP;
               end
            end
         end
         S_RD: begin
            if (flush_i) begin
               w_ce_n_nxt  = 1'b1;
               w_oe_n_nxt  = 1'b1;
               w_be_n_nxt  = 4'hF;
               w_state_nxt = S_IDLE;
            end else begin
               w_stall = 1'b1;
               if (r_cnt == '0) begin
                  w_load_nxt  = f_extend(r_op, r_lane, sram_dq_i);
                  w_ce_n_nxt  = 1'b1;
                  w_oe_n_nxt  = 1'b1;
                  w_be_n_nxt  = 4'hF;
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
         end
         S_WR_SETUP: begin
            w_stall     = 1'b1;
            w_we_n_nxt  = 1'b0;
            w_cnt_nxt   = CNT_W'(WRITE_PULSE - 1);
            w_state_nxt = S_WR_PULSE;
         end
         // A started write always runs its full WE pulse; flush is not honoured here.
         S_WR_PULSE: begin
            w_stall = 1'b1;
            if (r_cnt == '0) begin
               w_we_n_nxt  = 1'b1;
               w_state_nxt = S_WR_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_WR_HOLD: begin
            w_stall     = 1'b1;
            w_ce_n_nxt  = 1'b1;
            w_be_n_nxt  = 4'hF;
            w_dq_oe_nxt = 1'b0;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= OP_NOP;
         r_lane  <= 2'b00;
         r_load  <= 32'd0;
         r_addr  <= '0;
         r_dq    <= 32'd0;
         r_dq_oe <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_be_n  <= 4'hF;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_op    <= w_op_nxt;
         r_lane  <= w_lane_nxt;
         r_load  <= w_load_nxt;
         r_addr  <= w_addr_nxt;
         r_dq    <= w_dq_nxt;
         r_dq_oe <= w_dq_oe_nxt;
         r_ce_n  <= w_ce_n_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_we_n  <= w_we_n_nxt;
         r_be_n  <= w_be_n_nxt;
      end
   end

   assign load_data_o  = r_load;
   assign stall_o      = w_stall;
   assign sram_addr_o  = r_addr;
   assign sram_dq_o    = r_dq;
   assign sram_dq_oe_o = r_dq_oe;
   assign sram_ce_n_o  = r_ce_n;
   assign sram_oe_n_o  = r_oe_n;
   assign sram_we_n_o  = r_we_n;
   assign sram_be_n_o  = r_be_n;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed bench for mem_sram_responder: table of load/store vectors plus hand-written
// flush, back-to-back and reset sequences.
module tb_mem_sram_responder;

   localparam int ADDR_W      = 20;
   localparam int READ_WAIT   = 1;
   localparam int WRITE_PULSE = 1;
   localparam int LD_STALL    = 1 + READ_WAIT;
   localparam int ST_STALL    = 3 + WRITE_PULSE;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [3:0]        ramOp = OP_NOP;
   logic [31:0]       ramAddr = 32'd0;
   logic [31:0]       storeData = 32'd0;
   logic              flush = 1'b0;
   logic [31:0]       load_data;
   logic              stall;
   logic [ADDR_W-1:0] sram_addr;
   logic [31:0]       sram_dq_o;
   logic [31:0]       sram_dq_i = 32'd0;
   logic              sram_dq_oe;
   logic              sram_ce_n, sram_oe_n, sram_we_n;
   logic [3:0]        sram_be_n;
   logic [2:0]        dbg_state;

   int errors = 0;
   int checks = 0;

   mem_sram_responder #(
      .ADDR_W(ADDR_W), .READ_WAIT(READ_WAIT), .WRITE_PULSE(WRITE_PULSE)
   ) dut (
      .clk(clk), .rst(rst), .ramOp_i(ramOp), .ramAddr_i(ramAddr),
      .storeData_i(storeData), .flush_i(flush), .load_data_o(load_data),
      .stall_o(stall), .sram_addr_o(sram_addr), .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i), .sram_dq_oe_o(sram_dq_oe), .sram_ce_n_o(sram_ce_n),
      .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n), .sram_be_n_o(sram_be_n),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_load;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_dq;
   } vec_t;

   vec_t vecs[15];

   // Per-transaction observations gathered by run_op.
   int          m_stall, m_we, m_oe, m_dqoe;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_dq, m_load;
   logic        m_done_ce_n, m_done_dqoe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one op at the negedge of an IDLE cycle and samples pins each negedge until DONE.
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata);
      int cyc;
      @(negedge clk);
      ramOp = op; ramAddr = addr; storeData = wdata; sram_dq_i = rdata;
      m_stall = 0; m_we = 0; m_oe = 0; m_dqoe = 0;
      m_be = 4'hx; m_addr = 32'hx; m_dq = 32'hx;
      cyc = 0;
      #1;
      while (stall && cyc < 40) begin
         m_stall++;
         if (!sram_we_n) begin m_we++; m_be = sram_be_n; m_dq = sram_dq_o; m_addr = 32'(sram_addr); end
         if (!sram_oe_n) begin m_oe++; m_be = sram_be_n; m_addr = 32'(sram_addr); end
         if (sram_dq_oe) m_dqoe++;
         @(negedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 40) begin
         errors++; checks++;
         $display("FAIL run_op timeout: stall stuck high op=%0d", op);
      end
      m_load = load_data;
      m_done_ce_n = sram_ce_n;
      m_done_dqoe = sram_dq_oe;
   endtask

   task automatic chk_op(input string tag, input vec_t v);
      logic is_st;
      is_st = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
      chk({tag, " stall_len"}, m_stall, is_st ? ST_STALL : LD_STALL);
      chk({tag, " we_cycles"}, m_we, is_st ? WRITE_PULSE : 0);
      chk({tag, " oe_cycles"}, m_oe, is_st ? 0 : READ_WAIT);
      chk({tag, " dqoe_cycles"}, m_dqoe, is_st ? 2 + WRITE_PULSE : 0);
      chk({tag, " be_n"}, {28'd0, m_be}, {28'd0, v.exp_be});
      chk({tag, " sram_addr"}, m_addr, v.exp_addr);
      if (is_st) chk({tag, " dq_o"}, m_dq, v.exp_dq);
      chk({tag, " load_data"}, m_load, v.exp_load);
      chk({tag, " done ce_n"}, {31'd0, m_done_ce_n}, 32'd1);
      chk({tag, " done dq_oe"}, {31'd0, m_done_dqoe}, 32'd0);
   endtask

   task automatic chk_idle_pins(input string tag, input logic [31:0] exp_load);
      chk({tag, " stall"}, {31'd0, stall}, 32'd0);
      chk({tag, " ce_n"}, {31'd0, sram_ce_n}, 32'd1);
      chk({tag, " oe_n"}, {31'd0, sram_oe_n}, 32'd1);
      chk({tag, " we_n"}, {31'd0, sram_we_n}, 32'd1);
      chk({tag, " be_n"}, {28'd0, sram_be_n}, 32'hF);
      chk({tag, " dq_oe"}, {31'd0, sram_dq_oe}, 32'd0);
      chk({tag, " load_data"}, load_data, exp_load);
   endtask

   initial begin
      vecs[0]  = '{OP_LW,  32'h80000010, 32'h0,        32'h11223344, 32'h11223344, 32'h4,  4'h0,    32'h0};
      vecs[1]  = '{OP_LB,  32'h80000103, 32'h0,        32'h80FF7F01, 32'hFFFFFF80, 32'h40, 4'h0,    32'h0};
      vecs[2]  = '{OP_LBU, 32'h80000103, 32'h0,        32'h80FF7F01, 32'h00000080, 32'h40, 4'h0,    32'h0};
      vecs[3]  = '{OP_LH,  32'h80000102, 32'h0,        32'h80FF7F01, 32'hFFFF80FF, 32'h40, 4'h0,    32'h0};
      vecs[4]  = '{OP_LHU, 32'h80000103, 32'h0,        32'h80FF7F01, 32'h000080FF, 32'h40, 4'h0,    32'h0};
      vecs[5]  = '{OP_LB,  32'h80000101, 32'h0,        32'h80FF7F01, 32'h0000007F, 32'h40, 4'h0,    32'h0};
      vecs[6]  = '{OP_LH,  32'h80000100, 32'h0,        32'h80FF7F01, 32'h00007F01, 32'h40, 4'h0,    32'h0};
      vecs[7]  = '{OP_LW,  32'h80000017, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'h5,  4'h0,    32'h0};
      vecs[8]  = '{OP_SB,  32'h80000022, 32'h123456AB, 32'h0,        32'hCAFEF00D, 32'h8,  4'b1011, 32'hABABABAB};
      vecs[9]  = '{OP_SH,  32'h80000032, 32'hFFFF1234, 32'h0,        32'hCAFEF00D, 32'hC,  4'b0011, 32'h12341234};
      vecs[10] = '{OP_SW,  32'h80000043, 32'hDEADBEEF, 32'h0,        32'hCAFEF00D, 32'h10, 4'b0000, 32'hDEADBEEF};
      vecs[11] = '{OP_SB,  32'h80000001, 32'h0000005A, 32'h0,        32'hCAFEF00D, 32'h0,  4'b1101, 32'h5A5A5A5A};
      vecs[12] = '{OP_SH,  32'h80000000, 32'h0000BEEF, 32'h0,        32'hCAFEF00D, 32'h0,  4'b1100, 32'hBEEFBEEF};
      vecs[13] = '{OP_LBU, 32'h80000000, 32'h0,        32'h000000FE, 32'h000000FE, 32'h0,  4'h0,    32'h0};
      vecs[14] = '{OP_LB,  32'h80000000, 32'h0,        32'h000000FE, 32'hFFFFFFFE, 32'h0,  4'h0,    32'h0};

      // Reset values
      repeat (3) @(negedge clk);
      chk_idle_pins("reset", 32'd0);
      chk("reset addr", 32'(sram_addr), 32'd0);
      chk("reset dq_o", sram_dq_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk_idle_pins("post_reset", 32'd0);

      // Unknown op code behaves like NOP
      ramOp = 4'hF; ramAddr = 32'h80000010;
      #1 chk("unknown_op stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("unknown_op ce_n", {31'd0, sram_ce_n}, 32'd1);
      ramOp = OP_NOP;

      // Table vectors, issued back to back as a pipeline would
      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
         chk_op($sformatf("v%0d", i), vecs[i]);
      end
      @(negedge clk);
      ramOp = OP_NOP;
      #1 chk("after_table idle stall", {31'd0, stall}, 32'd0);

      // Back-to-back LW, SW, LW: three distinct SRAM cycles
      run_op(OP_LW, 32'h80000200, 32'h0, 32'hA5A5_0001);
      chk_op("b2b_lw0", '{OP_LW, 32'h80000200, 32'h0, 32'hA5A50001, 32'hA5A50001, 32'h80, 4'h0, 32'h0});
      run_op(OP_SW, 32'h80000204, 32'h0BADF00D, 32'h0);
      chk_op("b2b_sw", '{OP_SW, 32'h80000204, 32'h0BADF00D, 32'h0, 32'hA5A50001, 32'h81, 4'h0, 32'h0BADF00D});
      run_op(OP_LW, 32'h80000208, 32'h0, 32'h5A5A_0002);
      chk_op("b2b_lw1", '{OP_LW, 32'h80000208, 32'h0, 32'h5A5A0002, 32'h5A5A0002, 32'h82, 4'h0, 32'h0});

      // Flush during RD: abort, pins released next edge, load data kept
      @(negedge clk);
      ramOp = OP_LW; ramAddr = 32'h80000300; sram_dq_i = 32'h77777777;
      #1 chk("flush_rd idle stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("flush_rd oe_n in RD", {31'd0, sram_oe_n}, 32'd0);
      flush = 1'b1;
      #1 chk("flush_rd stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      flush = 1'b0; ramOp = OP_NOP;
      #1 chk_idle_pins("flush_rd after", 32'h5A5A0002);

      // Flush during WR_PULSE: write runs to completion
      @(negedge clk);
      ramOp = OP_SW; ramAddr = 32'h80000400; storeData = 32'h13579BDF;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1 chk("flush_wr pulse we_n", {31'd0, sram_we_n}, 32'd0);
      chk("flush_wr pulse stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      #1 chk("flush_wr hold stall", {31'd0, stall}, 32'd1);
      chk("flush_wr hold dq_oe", {31'd0, sram_dq_oe}, 32'd1);
      chk("flush_wr hold we_n", {31'd0, sram_we_n}, 32'd1);
      @(negedge clk);
      #1 chk("flush_wr done stall", {31'd0, stall}, 32'd0);
      chk("flush_wr done ce_n", {31'd0, sram_ce_n}, 32'd1);
      @(negedge clk);
      flush = 1'b0; ramOp = OP_NOP;

      // Reset during WR_PULSE: we_n returns high at the next edge
      @(negedge clk);
      ramOp = OP_SW; ramAddr = 32'h80000500; storeData = 32'h2468ACE0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_wr pulse we_n", {31'd0, sram_we_n}, 32'd0);
      rst = 1'b1; ramOp = OP_NOP;
      @(negedge clk);
      chk_idle_pins("rst_wr after", 32'd0);
      chk("rst_wr addr", 32'(sram_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
